// File: rtl/mano_io_pkg.sv
// Purpose : shared types for the Mano basic-computer I/O controller.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package mano_io_pkg;

  localparam int CHAR_WIDTH = 8;

  typedef logic [CHAR_WIDTH-1:0] char_t;

  // Input device handshake: wait for load low, accept one char, hold ack until load drops.
  typedef enum logic [1:0] {
    IN_DISARMED = 2'd0,
    IN_ARMED    = 2'd1,
    IN_ACKED    = 2'd2
  } in_state_e;

  // Output side: READY means FGO=1, BUSY means OUTR holds an unsent character.
  typedef enum logic {
    OUT_READY = 1'b0,
    OUT_BUSY  = 1'b1
  } out_state_e;

endpackage

// File: rtl/io_char_fifo.sv
// Purpose : small character FIFO with a registered head word.
// Latency : a push into an empty FIFO is visible on head_out after the same edge.
// Backpr. : push is dropped while full (caller must gate on full); pop while empty is ignored.
// Ports   : clock/reset (sync, active-high); push/data_in write side; pop/head_out read side;
//           empty/full describe the current contents, empty_next the contents after this edge.
module io_char_fifo
  import mano_io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [CHAR_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [CHAR_WIDTH-1:0] head_out,
  output logic                  empty,
  output logic                  full,
  output logic                  empty_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CHAR_WIDTH-1:0] mem_q [DEPTH];
  logic [CHAR_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CHAR_WIDTH-1:0] head_q, head_d;
  logic                  push_eff, pop_eff;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign push_eff = push & ~full;
  assign pop_eff  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (push_eff) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The head register must show the entry that will sit at rd_ptr after this edge.
    // When the FIFO is (or becomes) empty except for an incoming push, the pushed byte
    // has not reached mem_q yet, so it is forwarded directly.
    if (pop_eff) begin
      if (count_q > CW'(1)) begin
        head_d = mem_q[rd_ptr_d];
      end else if (push_eff) begin
        head_d = data_in;
      end
    end else if (push_eff && (count_q == '0)) begin
      head_d = data_in;
    end
  end

  assign empty_next = (count_d == '0);
  assign head_out   = head_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/mano_io_controller.sv
// Purpose : Mano I/O flags/registers (INPR/FGI, OUTR/FGO, IEN, IRQ) with a buffered input device.
// Latency : capture, INP pop, OUT load and flag/IRQ updates all take effect after one edge.
// Backpr. : input load waits without ack while the FIFO is full; OUT is ignored while FGO=0.
// Ports   : dev_* input device 4-phase load/ack; inpr/fgi/cpu_inp CPU input side;
//           outr_in/cpu_out/fgo + out_data/out_valid/out_ack output device;
//           cpu_ion/cpu_iof/cpu_int_ack drive IEN; irq_out = IEN & (FGI | FGO), registered.
module mano_io_controller
  import mano_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dev_data_in,
  input  logic       dev_load_in,
  output logic       dev_ack_out,
  output logic [7:0] inpr_out,
  output logic       fgi_out,
  input  logic       cpu_inp_in,
  input  logic [7:0] outr_in,
  input  logic       cpu_out_in,
  output logic       fgo_out,
  output logic [7:0] out_data_out,
  output logic       out_valid_out,
  input  logic       out_ack_in,
  input  logic       cpu_ion_in,
  input  logic       cpu_iof_in,
  input  logic       cpu_int_ack_in,
  output logic       ien_out,
  output logic       irq_out
);

  in_state_e  in_state_q, in_state_d;
  out_state_e out_state_q, out_state_d;
  logic [7:0] outr_q, outr_d;
  logic       ien_q, ien_d;
  logic       irq_q, irq_d;

  logic       fifo_push;
  logic       fifo_empty, fifo_full, fifo_empty_next;
  logic [7:0] fifo_head;

  io_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (fifo_push),
    .data_in    (dev_data_in),
    .pop        (cpu_inp_in),
    .head_out   (fifo_head),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .empty_next (fifo_empty_next)
  );

  // Input handshake. Starting DISARMED after reset means a load already held high
  // is not captured: its character may belong to a transfer the reset interrupted.
  always_comb begin
    in_state_d = in_state_q;
    fifo_push  = 1'b0;
    unique case (in_state_q)
      IN_DISARMED: if (!dev_load_in) in_state_d = IN_ARMED;
      IN_ARMED: begin
        // A full FIFO simply stalls here; the device keeps load high until space appears.
        if (dev_load_in && !fifo_full) begin
          fifo_push  = 1'b1;
          in_state_d = IN_ACKED;
        end
      end
      IN_ACKED:    if (!dev_load_in) in_state_d = IN_ARMED;
      default:     in_state_d = IN_DISARMED;
    endcase
  end

  // Output side: OUTR is only written while READY, so a busy character is never clobbered.
  always_comb begin
    out_state_d = out_state_q;
    outr_d      = outr_q;
    unique case (out_state_q)
      OUT_READY: begin
        if (cpu_out_in) begin
          outr_d      = outr_in;
          out_state_d = OUT_BUSY;
        end
      end
      OUT_BUSY:  if (out_ack_in) out_state_d = OUT_READY;
      default:   out_state_d = OUT_READY;
    endcase
  end

  // IEN: clears win over set; IRQ is built from next-state flags so it tracks them
  // with the same one-edge latency as the flags themselves.
  always_comb begin
    ien_d = ien_q;
    if (cpu_int_ack_in || cpu_iof_in) begin
      ien_d = 1'b0;
    end else if (cpu_ion_in) begin
      ien_d = 1'b1;
    end
    irq_d = ien_d & (~fifo_empty_next | (out_state_d == OUT_READY));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_state_q  <= IN_DISARMED;
      out_state_q <= OUT_READY;
      outr_q      <= '0;
      ien_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      outr_q      <= outr_d;
      ien_q       <= ien_d;
      irq_q       <= irq_d;
    end
  end

  assign dev_ack_out   = (in_state_q == IN_ACKED);
  assign inpr_out      = fifo_head;
  assign fgi_out       = ~fifo_empty;
  assign fgo_out       = (out_state_q == OUT_READY);
  assign out_valid_out = (out_state_q == OUT_BUSY);
  assign out_data_out  = outr_q;
  assign ien_out       = ien_q;
  assign irq_out       = irq_q;

endmodule
